uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver, 8N1, LSB first. It is the receive-side counterpart of `uart_tx` in the console mux: it consumes the `serial` line that a `uart_tx` drives and presents each received byte with a one-cycle valid strobe. A two-flop synchronizer makes it safe for asynchronous external pins. The bit period matches `uart_tx` through the same `CLK_PER_BIT` parameter, so a loopback `uart_tx` → `uart_rx` with equal parameters is lossless.

## Interface
- `CLK_PER_BIT`, 100, clock cycles per bit. Must be ≥ 4; `HALF = CLK_PER_BIT/2`, using integer division.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `serial` in 1: UART line. Idle high. Asynchronous to `clk`.
- `data` out 8: last correctly framed byte. Holds its value between frames.
- `data_valid` out 1: one-cycle pulse when `data` is updated.
- `framing_err` out 1: one-cycle pulse when the stop bit is sampled as 0.
- `busy` out 1: high in every state except IDLE.

## Operation
- Synchronizer: 2 flops, both reset to 1. `rx_s` is the second flop. All logic uses only `rx_s`.
- Bit counter: counts 0..CLK_PER_BIT-1. Sample index is 0..7.
- States:
  - IDLE: when `rx_s`==0, go to START and clear the counter.
  - START: at counter == HALF-1, sample the line.
    - Sample 0: clear the counter, go to DATA with index 0.
    - Sample 1: treat as a glitch, return to IDLE with no outputs.
  - DATA: every CLK_PER_BIT cycles from the start sample point, sample one bit into shift register bit `index`. After index 7, go to STOP.
  - STOP: sample once, CLK_PER_BIT cycles after bit 7.
    - Sample 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
    - Sample 0: pulse `framing_err`, leave `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from re-triggering as a new frame.
- A start edge can be detected on the first cycle back in IDLE. Back-to-back frames with a single stop bit are received without loss.
- Reset values: `data`=8'h00, `data_valid`=0, `framing_err`=0, `busy`=0, state IDLE, shift register 0, counters 0.
- Reset asserted mid-frame aborts the frame immediately, with no pulse. After release, the receiver resynchronizes on the next falling edge of `rx_s`.
- `data_valid` and `framing_err` are never high together.

## Timing
- Let T0 be the first rising edge at which `rx_s`==0. This is 2 clocks after the pin falls.
- Sample k (k=0 start, 1..8 data, 9 stop) is taken at T0 + HALF + k·CLK_PER_BIT, plus D.
  - D = 0 without majority voting.
  - D = 1 with majority voting.
- `data_valid`/`framing_err` are asserted for the single cycle after sample 9 (registered).
- `busy` rises the cycle after T0. It falls together with the `data_valid` pulse, or when WAIT_HIGH exits.
- Pin-to-`data_valid` latency: 2 + HALF + 9·CLK_PER_BIT + D + 1 clocks.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each bit value (start, data, stop) is the 2-of-3 majority of `rx_s` at counter points HALF-2, HALF-1 and HALF.
  - The decision is made at HALF, so D = 1.
  - A single-cycle glitch at the sample point is rejected.
- Undefined:
  - Each bit is a single sample of `rx_s` at HALF-1, so D = 0.
  - No vote registers are instantiated.

## Test plan
- Frame 0xA5 with CLK_PER_BIT=100 (bits 1,0,1,0,0,1,0,1 LSB first, stop 1) → exactly one `data_valid` pulse, `data`==8'hA5, `framing_err` stays 0, `busy` low afterwards.
- Frames 0x00 then 0xFF back-to-back, one stop bit each → two `data_valid` pulses exactly 10·CLK_PER_BIT apart, with `data` 8'h00 then 8'hFF.
- Line low for 20 cycles, then high → no `data_valid` or `framing_err`, `busy` back to 0 within 1 cycle of the START sample.
- Frame 0x3C with stop bit 0, line held low for 3·CLK_PER_BIT, then high, then frame 0x81:
  - One `framing_err` pulse, `data` stays at its previous value.
  - No new frame is detected while the line is low.
  - Then `data`==8'h81 with `data_valid`.
- `rst_n` pulsed low during bit 4 of a 0x55 frame, then a full 0x96 frame → no pulse from the aborted frame; `data`==8'h96 received correctly.
- With `UART_RX_MAJORITY_EN`: 0xF0 frame with a 1-cycle inverted glitch at the HALF-1 point of bit 2 → `data`==8'hF0. Without the macro, the same stimulus → `data`==8'hF4.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with a two-flop input synchronizer.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around every bit sample point.
module uart_rx #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_err,
  output logic       busy
);
  // state     | meaning
  // IDLE      | line idle, waiting for rx_s to fall
  // START     | timing to the middle of the start bit
  // DATA      | sampling data bits 0..7
  // STOP      | sampling the stop bit
  // WAIT_HIGH | framing error seen, waiting for the line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  localparam int HALF = CLK_PER_BIT / 2;
  localparam int CW   = $clog2(CLK_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = HALF;
`else
  localparam int START_PT = HALF - 1;
`endif
  localparam logic [CW-1:0] START_PT_C = CW'(START_PT);
  localparam logic [CW-1:0] BIT_PT_C   = CW'(CLK_PER_BIT - 1);

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          framing_err_q, framing_err_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] pt;
  logic          at_pt;
  logic          bit_val;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]    vote_q, vote_d;
`endif

  always_comb begin
    sync1_d       = serial;
    rx_s_d        = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    busy_d        = busy_q;
    pt            = (state_q == START) ? START_PT_C : BIT_PT_C;
    at_pt         = (cnt_q == pt);
`ifdef UART_RX_MAJORITY_EN
    // The two earlier votes are captured one and two cycles before the decision point.
    vote_d = vote_q;
    if (cnt_q == pt - CW'(2)) vote_d[0] = rx_s_q;
    if (cnt_q == pt - CW'(1)) vote_d[1] = rx_s_q;
    bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
    bit_val = rx_s_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (at_pt) begin
          cnt_d = '0;
          idx_d = 3'd0;
          if (bit_val) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (at_pt) begin
          cnt_d          = '0;
          shift_d[idx_q] = bit_val;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (at_pt) begin
          cnt_d = '0;
          if (bit_val) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shift_q       <= 8'h00;
      data_q        <= 8'h00;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      vote_q        <= 2'b00;
`endif
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      rx_s_q        <= rx_s_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
      busy_q        <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      vote_q        <= vote_d;
`endif
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign busy        = busy_q;

endmodule
